// File: rtl/id_stage_pipe_if.sv
// id_stage_pipe_if
// Bundles every signal of the decode stage except clk/rst.
//   Fetch side : in_valid, in_ready, instr, pc_in
//   Reg file   : rf_a1, rf_a2 (addresses out), rd1, rd2 (data in)
//   EX side    : out_valid, out_ready and the ID/EX payload
//                (exe_cmd, wb_en, mem_r_en, mem_w_en, src1, src2, dest,
//                val1, val2, st_data)
//   Control    : flush in, redirect_valid/redirect_pc out,
//                bubble_cnt/kill_cnt performance counters out
// modport slave  : the decode stage itself
// modport master : the environment around it (fetch, reg file, EX)
interface id_stage_pipe_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CNT_W  = 16
);
    logic              in_valid;
    logic              in_ready;
    logic [31:0]       instr;
    logic [XLEN-1:0]   pc_in;
    logic [XLEN-1:0]   rd1;
    logic [XLEN-1:0]   rd2;
    logic [REG_AW-1:0] rf_a1;
    logic [REG_AW-1:0] rf_a2;
    logic              flush;
    logic              out_valid;
    logic              out_ready;
    logic [3:0]        exe_cmd;
    logic              wb_en;
    logic              mem_r_en;
    logic              mem_w_en;
    logic [REG_AW-1:0] src1;
    logic [REG_AW-1:0] src2;
    logic [REG_AW-1:0] dest;
    logic [XLEN-1:0]   val1;
    logic [XLEN-1:0]   val2;
    logic [XLEN-1:0]   st_data;
    logic              redirect_valid;
    logic [XLEN-1:0]   redirect_pc;
    logic [CNT_W-1:0]  bubble_cnt;
    logic [CNT_W-1:0]  kill_cnt;

    modport slave (
        input  in_valid, instr, pc_in, rd1, rd2, flush, out_ready,
        output in_ready, rf_a1, rf_a2, out_valid, exe_cmd, wb_en, mem_r_en,
               mem_w_en, src1, src2, dest, val1, val2, st_data,
               redirect_valid, redirect_pc, bubble_cnt, kill_cnt
    );

    modport master (
        output in_valid, instr, pc_in, rd1, rd2, flush, out_ready,
        input  in_ready, rf_a1, rf_a2, out_valid, exe_cmd, wb_en, mem_r_en,
               mem_w_en, src1, src2, dest, val1, val2, st_data,
               redirect_valid, redirect_pc, bubble_cnt, kill_cnt
    );
endinterface

// File: rtl/id_stage_pipe.sv
// id_stage_pipe
// Registered instruction-decode stage of the 5-stage integer pipeline.
// Decodes the instruction and picks operands from the register-file data,
// resolves branches here (one-cycle redirect pulse to fetch and dropping of
// KILL_SLOTS wrong-path instructions), stalls one cycle on a load-use pair,
// and presents the result through a valid/ready ID/EX register.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - id_stage_pipe_if.slave (fetch, reg file, EX, flush, redirect,
//          saturating bubble/kill counters)
module id_stage_pipe #(
    parameter int XLEN       = 32,
    parameter int REG_AW     = 5,
    parameter int KILL_SLOTS = 1,
    parameter int CNT_W      = 16
) (
    input  logic                clk,
    input  logic                rst,
    id_stage_pipe_if.slave      bus
);
    localparam logic [3:0] CMD_ADD = 4'd0, CMD_SUB = 4'd1, CMD_AND = 4'd2,
                           CMD_OR  = 4'd3, CMD_NOR = 4'd4, CMD_XOR = 4'd5,
                           CMD_SLA = 4'd6, CMD_SLL = 4'd7, CMD_SRA = 4'd8,
                           CMD_SRL = 4'd9, CMD_NOP = 4'd10;
    localparam logic [1:0] KILL_INIT = 2'(KILL_SLOTS);

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return (&c) ? c : c + 1'b1;
    endfunction

    // Stage p0: combinational decode of the presented instruction
    logic [5:0]              op;
    logic [REG_AW-1:0]       rs_a, rt_a, rd_a;
    logic signed [XLEN-1:0]  imm_sext;
    logic [XLEN-1:0]         target_p0;
    logic [3:0]              cmd_p0;
    logic                    wb_p0, mr_p0, mw_p0, rtype_p0, uses_rt_p0, taken_p0;
    logic [REG_AW-1:0]       src2_p0, dest_p0;
    logic [XLEN-1:0]         val2_p0, st_p0;

    assign op        = bus.instr[31:26];
    assign rs_a      = REG_AW'(bus.instr[25:21]);
    assign rt_a      = REG_AW'(bus.instr[20:16]);
    assign rd_a      = REG_AW'(bus.instr[15:11]);
    assign imm_sext  = {{(XLEN-16){bus.instr[15]}}, bus.instr[15:0]};
    // Target wraps modulo 2^XLEN; the word offset is signed.
    assign target_p0 = bus.pc_in + XLEN'(4) + XLEN'(imm_sext <<< 2);
    assign bus.rf_a1 = rs_a;
    assign bus.rf_a2 = rt_a;

    always_comb begin
        cmd_p0     = CMD_NOP;
        wb_p0      = 1'b0;
        mr_p0      = 1'b0;
        mw_p0      = 1'b0;
        rtype_p0   = 1'b0;
        uses_rt_p0 = 1'b0;
        taken_p0   = 1'b0;
        src2_p0    = '0;
        dest_p0    = '0;
        val2_p0    = '0;
        st_p0      = '0;
        case (op)
            6'd0:  begin src2_p0 = rt_a; dest_p0 = rd_a; val2_p0 = bus.rd2; end
            6'd1:  begin cmd_p0 = CMD_ADD; rtype_p0 = 1'b1; end
            6'd3:  begin cmd_p0 = CMD_SUB; rtype_p0 = 1'b1; end
            6'd5:  begin cmd_p0 = CMD_AND; rtype_p0 = 1'b1; end
            6'd6:  begin cmd_p0 = CMD_OR;  rtype_p0 = 1'b1; end
            6'd7:  begin cmd_p0 = CMD_NOR; rtype_p0 = 1'b1; end
            6'd8:  begin cmd_p0 = CMD_XOR; rtype_p0 = 1'b1; end
            6'd9:  begin cmd_p0 = CMD_SLA; rtype_p0 = 1'b1; end
            6'd10: begin cmd_p0 = CMD_SLL; rtype_p0 = 1'b1; end
            6'd11: begin cmd_p0 = CMD_SRA; rtype_p0 = 1'b1; end
            6'd12: begin cmd_p0 = CMD_SRL; rtype_p0 = 1'b1; end
            6'd32, 6'd33, 6'd36: begin
                cmd_p0  = (op == 6'd33) ? CMD_SUB : CMD_ADD;
                wb_p0   = 1'b1;
                mr_p0   = (op == 6'd36);
                dest_p0 = rt_a;
                val2_p0 = imm_sext;
            end
            6'd37: begin
                cmd_p0     = CMD_ADD;
                mw_p0      = 1'b1;
                uses_rt_p0 = 1'b1;
                src2_p0    = rt_a;
                val2_p0    = imm_sext;
                st_p0      = bus.rd2;
            end
            6'd40: taken_p0 = (bus.rd1 == '0);
            6'd41: begin taken_p0 = (bus.rd1 != bus.rd2); uses_rt_p0 = 1'b1; end
            6'd42: taken_p0 = 1'b1;
            default: ;
        endcase
        if (rtype_p0) begin
            wb_p0      = 1'b1;
            uses_rt_p0 = 1'b1;
            src2_p0    = rt_a;
            dest_p0    = rd_a;
            val2_p0    = bus.rd2;
        end
        if (dest_p0 == '0) wb_p0 = 1'b0;
    end

    // Stage p1: ID/EX output register, kill window, counters
    logic                out_valid_p1, wb_p1, mr_p1, mw_p1, redirect_valid_p1;
    logic [3:0]          cmd_p1;
    logic [REG_AW-1:0]   src1_p1, src2_p1, dest_p1;
    logic [XLEN-1:0]     val1_p1, val2_p1, st_p1, redirect_pc_p1;
    logic [1:0]          kill_left;
    logic [CNT_W-1:0]    bubble_cnt, kill_cnt;
    logic                hazard, killing, accept;

    // Only a load sitting in ID/EX can stall; ALU results are forwarded.
    assign hazard  = out_valid_p1 & mr_p1 & (dest_p1 != '0) &
                     ((dest_p1 == rs_a) | (uses_rt_p0 & (dest_p1 == rt_a)));
    assign killing = (kill_left != 2'd0);
    // Wrong-path instructions are swallowed regardless of EX back-pressure.
    assign bus.in_ready = (killing & ~bus.flush) |
                          ((~out_valid_p1 | bus.out_ready) & ~hazard & ~bus.flush);
    assign accept = bus.in_valid & bus.in_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_p1      <= 1'b0;
            cmd_p1            <= CMD_NOP;
            wb_p1             <= 1'b0;
            mr_p1             <= 1'b0;
            mw_p1             <= 1'b0;
            src1_p1           <= '0;
            src2_p1           <= '0;
            dest_p1           <= '0;
            val1_p1           <= '0;
            val2_p1           <= '0;
            st_p1             <= '0;
            redirect_valid_p1 <= 1'b0;
            redirect_pc_p1    <= '0;
            kill_left         <= 2'd0;
            bubble_cnt        <= '0;
            kill_cnt          <= '0;
        end else if (bus.flush) begin
            out_valid_p1      <= 1'b0;
            kill_left         <= 2'd0;
            redirect_valid_p1 <= 1'b0;
        end else begin
            redirect_valid_p1 <= 1'b0;
            if (bus.out_ready) out_valid_p1 <= 1'b0;
            if (accept && killing) begin
                kill_left <= kill_left - 2'd1;
                kill_cnt  <= sat_inc(kill_cnt);
            end else if (accept) begin
                out_valid_p1 <= 1'b1;
                cmd_p1       <= cmd_p0;
                wb_p1        <= wb_p0;
                mr_p1        <= mr_p0;
                mw_p1        <= mw_p0;
                src1_p1      <= rs_a;
                src2_p1      <= src2_p0;
                dest_p1      <= dest_p0;
                val1_p1      <= bus.rd1;
                val2_p1      <= val2_p0;
                st_p1        <= st_p0;
                if (taken_p0) begin
                    kill_left         <= KILL_INIT;
                    redirect_valid_p1 <= 1'b1;
                    redirect_pc_p1    <= target_p0;
                end
            end else if (bus.in_valid && hazard && bus.out_ready && !killing) begin
                bubble_cnt <= sat_inc(bubble_cnt);
            end
        end
    end

    assign bus.out_valid      = out_valid_p1;
    assign bus.exe_cmd        = cmd_p1;
    assign bus.wb_en          = wb_p1;
    assign bus.mem_r_en       = mr_p1;
    assign bus.mem_w_en       = mw_p1;
    assign bus.src1           = src1_p1;
    assign bus.src2           = src2_p1;
    assign bus.dest           = dest_p1;
    assign bus.val1           = val1_p1;
    assign bus.val2           = val2_p1;
    assign bus.st_data        = st_p1;
    assign bus.redirect_valid = redirect_valid_p1;
    assign bus.redirect_pc    = redirect_pc_p1;
    assign bus.bubble_cnt     = bubble_cnt;
    assign bus.kill_cnt       = kill_cnt;
endmodule

// File: tb/tb_id_stage_pipe.sv
// tb_id_stage_pipe
// Bench for id_stage_pipe. Expected ID/EX payloads are queued when an
// instruction is driven and popped when EX takes the output; control
// outputs and counters are compared inline in each scenario task.
// Counters are built 2 bits wide so saturation is reachable.
module tb_id_stage_pipe;
    localparam int XLEN = 32, REG_AW = 5, KILL_SLOTS = 1, CNT_W = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    id_stage_pipe_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CNT_W(CNT_W)) bus ();

    id_stage_pipe #(.XLEN(XLEN), .REG_AW(REG_AW), .KILL_SLOTS(KILL_SLOTS),
                    .CNT_W(CNT_W)) dut (.clk(clk), .rst(rst), .bus(bus));

    typedef struct packed {
        logic [3:0]  cmd;
        logic        wb, mr, mw;
        logic [4:0]  s1, s2, d;
        logic [31:0] v1, v2, st;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    function automatic logic [31:0] rt_ins(input int op, input int rd, input int rs, input int rt);
        return {6'(op), 5'(rs), 5'(rt), 5'(rd), 11'd0};
    endfunction

    function automatic logic [31:0] it_ins(input int op, input int rs, input int rt, input logic [15:0] imm);
        return {6'(op), 5'(rs), 5'(rt), imm};
    endfunction

    task automatic push(input logic [3:0] cmd, input logic wb, input logic mr, input logic mw,
                        input int s1, input int s2, input int d,
                        input logic [31:0] v1, input logic [31:0] v2, input logic [31:0] st);
        exp_t e;
        e.cmd = cmd; e.wb = wb; e.mr = mr; e.mw = mw;
        e.s1 = 5'(s1); e.s2 = 5'(s2); e.d = 5'(d);
        e.v1 = v1; e.v2 = v2; e.st = st;
        exp_q.push_back(e);
    endtask

    task automatic drive(input logic [31:0] ins, input logic [31:0] pc,
                         input logic [31:0] r1, input logic [31:0] r2);
        bus.in_valid = 1'b1; bus.instr = ins; bus.pc_in = pc; bus.rd1 = r1; bus.rd2 = r2;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0; bus.instr = '0; bus.pc_in = '0; bus.rd1 = '0; bus.rd2 = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Scoreboard: EX takes the output when out_valid & out_ready at the edge.
    always @(negedge clk) begin
        if (!rst && !bus.flush && bus.out_valid === 1'b1 && bus.out_ready === 1'b1) begin
            exp_t a, e;
            a.cmd = bus.exe_cmd; a.wb = bus.wb_en; a.mr = bus.mem_r_en; a.mw = bus.mem_w_en;
            a.s1 = bus.src1; a.s2 = bus.src2; a.d = bus.dest;
            a.v1 = bus.val1; a.v2 = bus.val2; a.st = bus.st_data;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard_unexpected_output got %h expected nothing", a);
            end else begin
                e = exp_q.pop_front();
                if (a !== e) begin
                    errors++;
                    $display("FAIL scoreboard_payload got %h expected %h", a, e);
                end
            end
        end
    end

    task automatic test_reset();
        rst = 1'b1; bus.flush = 1'b0; bus.out_ready = 1'b1; idle();
        tick(); tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %b expected 0", bus.out_valid); end
        checks++; if (bus.exe_cmd !== 4'd10) begin errors++; $display("FAIL reset_exe_cmd got %0d expected 10", bus.exe_cmd); end
        checks++; if ({bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.redirect_valid} !== 4'b0) begin
            errors++; $display("FAIL reset_enables got %b expected 0000", {bus.wb_en, bus.mem_r_en, bus.mem_w_en, bus.redirect_valid}); end
        checks++; if ({bus.val1, bus.val2, bus.st_data, bus.redirect_pc} !== 128'd0) begin
            errors++; $display("FAIL reset_data got %h expected 0", {bus.val1, bus.val2, bus.st_data, bus.redirect_pc}); end
        checks++; if ({bus.bubble_cnt, bus.kill_cnt} !== '0) begin
            errors++; $display("FAIL reset_counters got %h expected 0", {bus.bubble_cnt, bus.kill_cnt}); end
        rst = 1'b0;
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b expected 1", bus.in_ready); end
    endtask

    task automatic test_rtype();
        drive(rt_ins(1, 3, 1, 2), 32'h0, 32'd5, 32'd7);
        push(4'd0, 1, 0, 0, 1, 2, 3, 32'd5, 32'd7, 32'd0);
        #1;
        checks++; if (bus.in_ready !== 1'b1 || bus.rf_a1 !== 5'd1 || bus.rf_a2 !== 5'd2) begin
            errors++; $display("FAIL rtype_addr_ready got %b/%0d/%0d expected 1/1/2", bus.in_ready, bus.rf_a1, bus.rf_a2); end
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL rtype_issue got %b expected 1", bus.out_valid); end
        drive(rt_ins(8, 9, 4, 5), 32'h4, 32'h0000F0F0, 32'h00000FF0);
        push(4'd5, 1, 0, 0, 4, 5, 9, 32'h0000F0F0, 32'h00000FF0, 32'd0);
        tick();
        drive(rt_ins(7, 10, 6, 7), 32'h8, 32'h1, 32'h2);
        push(4'd4, 1, 0, 0, 6, 7, 10, 32'h1, 32'h2, 32'd0);
        tick();
        drive(rt_ins(12, 11, 8, 9), 32'hC, 32'h80000000, 32'h4);
        push(4'd9, 1, 0, 0, 8, 9, 11, 32'h80000000, 32'h4, 32'd0);
        tick();
        drive(rt_ins(1, 0, 2, 3), 32'h10, 32'h9, 32'hA);   // dest r0 kills writeback
        push(4'd0, 0, 0, 0, 2, 3, 0, 32'h9, 32'hA, 32'd0);
        tick();
        drive(rt_ins(0, 4, 5, 6), 32'h14, 32'h3, 32'h8);   // R-type NOP
        push(4'd10, 0, 0, 0, 5, 6, 4, 32'h3, 32'h8, 32'd0);
        tick();
        idle(); tick();
        checks++; if (bus.out_valid !== 1'b0) begin errors++; $display("FAIL rtype_drain got %b expected 0", bus.out_valid); end
    endtask

    task automatic test_itype();
        drive(it_ins(32, 2, 4, 16'hFFFE), 32'h20, 32'd10, 32'd0);
        push(4'd0, 1, 0, 0, 2, 0, 4, 32'd10, 32'hFFFFFFFE, 32'd0);
        tick();
        drive(it_ins(33, 3, 5, 16'h0010), 32'h24, 32'd20, 32'd99);
        push(4'd1, 1, 0, 0, 3, 0, 5, 32'd20, 32'h10, 32'd0);
        tick();
        drive(it_ins(36, 1, 7, 16'h8000), 32'h28, 32'h400, 32'd0);
        push(4'd0, 1, 1, 0, 1, 0, 7, 32'h400, 32'hFFFF8000, 32'd0);
        tick();
        drive(it_ins(37, 1, 8, 16'h0010), 32'h2C, 32'h100, 32'h1234);
        push(4'd0, 0, 0, 1, 1, 8, 0, 32'h100, 32'h10, 32'h1234);
        tick();
        checks++; if (bus.mem_w_en !== 1'b1 || bus.wb_en !== 1'b0 || bus.st_data !== 32'h1234) begin
            errors++; $display("FAIL store_fields got %b/%b/%h expected 1/0/00001234", bus.mem_w_en, bus.wb_en, bus.st_data); end
        drive(it_ins(63, 9, 9, 16'h1234), 32'h30, 32'h55, 32'h66);   // unknown opcode
        push(4'd10, 0, 0, 0, 9, 0, 0, 32'h55, 32'd0, 32'd0);
        tick();
        idle(); tick();
    endtask

    task automatic test_load_use();
        drive(it_ins(36, 0, 6, 16'h0004), 32'h40, 32'h200, 32'd0);
        push(4'd0, 1, 1, 0, 0, 0, 6, 32'h200, 32'h4, 32'd0);
        tick();
        drive(rt_ins(1, 3, 6, 1), 32'h44, 32'h77, 32'h1);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL loaduse_stall got %b expected 0", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.bubble_cnt !== 2'd1) begin
            errors++; $display("FAIL loaduse_bubble got %b/%0d expected 0/1", bus.out_valid, bus.bubble_cnt); end
        push(4'd0, 1, 0, 0, 6, 1, 3, 32'h77, 32'h1, 32'd0);
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL loaduse_issue got %b expected 1", bus.out_valid); end
        // Load to r0 never stalls a reader of r0.
        drive(it_ins(36, 0, 0, 16'h0000), 32'h48, 32'h0, 32'd0);
        push(4'd0, 0, 1, 0, 0, 0, 0, 32'h0, 32'h0, 32'd0);
        tick();
        drive(rt_ins(1, 2, 0, 1), 32'h4C, 32'h0, 32'h3);
        push(4'd0, 1, 0, 0, 0, 1, 2, 32'h0, 32'h3, 32'd0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL loaduse_r0 got %b expected 1", bus.in_ready); end
        tick();
        // rt dependence stalls an R-type reader.
        drive(it_ins(36, 0, 5, 16'h0000), 32'h50, 32'h0, 32'd0);
        push(4'd0, 1, 1, 0, 0, 0, 5, 32'h0, 32'h0, 32'd0);
        tick();
        drive(rt_ins(3, 2, 1, 5), 32'h54, 32'h8, 32'h9);
        tick();
        push(4'd1, 1, 0, 0, 1, 5, 2, 32'h8, 32'h9, 32'd0);
        tick();
        checks++; if (bus.bubble_cnt !== 2'd2) begin errors++; $display("FAIL loaduse_rt got %0d expected 2", bus.bubble_cnt); end
        // ADDI writes rt but does not read it: no stall.
        drive(it_ins(36, 0, 5, 16'h0000), 32'h58, 32'h0, 32'd0);
        push(4'd0, 1, 1, 0, 0, 0, 5, 32'h0, 32'h0, 32'd0);
        tick();
        drive(it_ins(32, 1, 5, 16'h0001), 32'h5C, 32'h8, 32'h0);
        push(4'd0, 1, 0, 0, 1, 0, 5, 32'h8, 32'h1, 32'd0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL loaduse_addi_rt got %b expected 1", bus.in_ready); end
        tick();
        idle(); tick();
    endtask

    task automatic test_branch();
        drive(it_ins(41, 1, 2, 16'h0003), 32'h100, 32'd1, 32'd2);
        push(4'd10, 0, 0, 0, 1, 0, 0, 32'd1, 32'd0, 32'd0);
        tick();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h110) begin
            errors++; $display("FAIL bne_redirect got %b/%h expected 1/00000110", bus.redirect_valid, bus.redirect_pc); end
        drive(rt_ins(1, 3, 1, 2), 32'h104, 32'd1, 32'd1);   // wrong path, dropped
        tick();
        checks++; if (bus.redirect_valid !== 1'b0 || bus.out_valid !== 1'b0 || bus.kill_cnt !== 2'd1) begin
            errors++; $display("FAIL bne_kill got %b/%b/%0d expected 0/0/1", bus.redirect_valid, bus.out_valid, bus.kill_cnt); end
        drive(it_ins(40, 3, 0, 16'h0008), 32'h200, 32'd1, 32'd0);   // not taken
        push(4'd10, 0, 0, 0, 3, 0, 0, 32'd1, 32'd0, 32'd0);
        tick();
        checks++; if (bus.redirect_valid !== 1'b0) begin errors++; $display("FAIL bez_not_taken got %b expected 0", bus.redirect_valid); end
        drive(rt_ins(1, 4, 1, 2), 32'h204, 32'd3, 32'd4);
        push(4'd0, 1, 0, 0, 1, 2, 4, 32'd3, 32'd4, 32'd0);
        tick();
        checks++; if (bus.out_valid !== 1'b1 || bus.kill_cnt !== 2'd1) begin
            errors++; $display("FAIL bez_no_drop got %b/%0d expected 1/1", bus.out_valid, bus.kill_cnt); end
        drive(it_ins(42, 0, 0, 16'hFFFF), 32'h300, 32'd0, 32'd0);   // backward jump
        push(4'd10, 0, 0, 0, 0, 0, 0, 32'd0, 32'd0, 32'd0);
        tick();
        checks++; if (bus.redirect_valid !== 1'b1 || bus.redirect_pc !== 32'h300) begin
            errors++; $display("FAIL jmp_back got %b/%h expected 1/00000300", bus.redirect_valid, bus.redirect_pc); end
        drive(rt_ins(1, 3, 1, 2), 32'h304, 32'd1, 32'd1);
        tick();
        idle(); tick();
        checks++; if (bus.kill_cnt !== 2'd2) begin errors++; $display("FAIL jmp_kill got %0d expected 2", bus.kill_cnt); end
    endtask

    task automatic test_backpressure();
        bus.out_ready = 1'b0;
        drive(rt_ins(1, 3, 1, 2), 32'h400, 32'h11, 32'h22);
        push(4'd0, 1, 0, 0, 1, 2, 3, 32'h11, 32'h22, 32'd0);
        tick();
        drive(rt_ins(8, 7, 4, 5), 32'h404, 32'h33, 32'h44);
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++;
            if (bus.out_valid !== 1'b1 || bus.val1 !== 32'h11 || bus.dest !== 5'd3 ||
                bus.exe_cmd !== 4'd0 || bus.in_ready !== 1'b0) begin
                errors++;
                $display("FAIL hold_stable cycle %0d got %b/%h/%0d/%0d/%b expected 1/00000011/3/0/0",
                         i, bus.out_valid, bus.val1, bus.dest, bus.exe_cmd, bus.in_ready);
            end
        end
        bus.out_ready = 1'b1;
        push(4'd5, 1, 0, 0, 4, 5, 7, 32'h33, 32'h44, 32'd0);
        #1;
        checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL release_ready got %b expected 1", bus.in_ready); end
        tick();
        checks++; if (bus.exe_cmd !== 4'd5 || bus.val1 !== 32'h33) begin
            errors++; $display("FAIL release_issue got %0d/%h expected 5/00000033", bus.exe_cmd, bus.val1); end
        idle(); tick();
    endtask

    task automatic test_flush();
        drive(rt_ins(1, 3, 1, 2), 32'h500, 32'd1, 32'd2);   // squashed below
        tick();
        bus.flush = 1'b1;
        drive(it_ins(41, 1, 2, 16'h0003), 32'h504, 32'd1, 32'd2);
        #1;
        checks++; if (bus.in_ready !== 1'b0) begin errors++; $display("FAIL flush_in_ready got %b expected 0", bus.in_ready); end
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.redirect_valid !== 1'b0 || bus.kill_cnt !== 2'd2) begin
            errors++; $display("FAIL flush_squash got %b/%b/%0d expected 0/0/2", bus.out_valid, bus.redirect_valid, bus.kill_cnt); end
        bus.flush = 1'b0;
        drive(rt_ins(5, 6, 1, 2), 32'h508, 32'hF0, 32'h3C);
        push(4'd2, 1, 0, 0, 1, 2, 6, 32'hF0, 32'h3C, 32'd0);
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL flush_recover got %b expected 1", bus.out_valid); end
        idle(); tick();
    endtask

    task automatic test_saturate();
        for (int i = 0; i < 2; i++) begin
            drive(it_ins(36, 0, 6, 16'h0000), 32'h600, 32'h0, 32'h0);
            push(4'd0, 1, 1, 0, 0, 0, 6, 32'h0, 32'h0, 32'd0);
            tick();
            drive(rt_ins(1, 3, 6, 1), 32'h604, 32'h5, 32'h6);
            tick();
            push(4'd0, 1, 0, 0, 6, 1, 3, 32'h5, 32'h6, 32'd0);
            tick();
            drive(it_ins(42, 0, 0, 16'h0000), 32'h608, 32'h0, 32'h0);
            push(4'd10, 0, 0, 0, 0, 0, 0, 32'h0, 32'h0, 32'd0);
            tick();
            drive(rt_ins(1, 3, 1, 2), 32'h60C, 32'h1, 32'h1);
            tick();
            idle(); tick();
        end
        checks++; if (bus.bubble_cnt !== 2'd3 || bus.kill_cnt !== 2'd3) begin
            errors++; $display("FAIL counters_saturate got %0d/%0d expected 3/3", bus.bubble_cnt, bus.kill_cnt); end
    endtask

    task automatic test_mid_reset();
        drive(it_ins(42, 1, 0, 16'h0010), 32'h700, 32'h9, 32'h0);   // leaves a kill pending
        tick();
        rst = 1'b1;
        drive(rt_ins(1, 3, 1, 2), 32'h704, 32'h1, 32'h1);
        tick();
        checks++; if (bus.out_valid !== 1'b0 || bus.exe_cmd !== 4'd10 || bus.redirect_valid !== 1'b0 ||
                      bus.redirect_pc !== 32'h0 || bus.val1 !== 32'h0 || bus.src1 !== 5'd0) begin
            errors++; $display("FAIL midreset_outputs got %b/%0d/%b/%h/%h/%0d expected 0/10/0/0/0/0",
                               bus.out_valid, bus.exe_cmd, bus.redirect_valid, bus.redirect_pc, bus.val1, bus.src1); end
        checks++; if (bus.bubble_cnt !== 2'd0 || bus.kill_cnt !== 2'd0) begin
            errors++; $display("FAIL midreset_counters got %0d/%0d expected 0/0", bus.bubble_cnt, bus.kill_cnt); end
        rst = 1'b0;
        push(4'd0, 1, 0, 0, 1, 2, 3, 32'h1, 32'h1, 32'd0);
        tick();
        checks++; if (bus.out_valid !== 1'b1) begin errors++; $display("FAIL midreset_no_kill got %b expected 1", bus.out_valid); end
        idle(); tick(); tick();
    endtask

    initial begin
        bus.flush = 1'b0; bus.out_ready = 1'b1; idle();
        test_reset();
        test_rtype();
        test_itype();
        test_load_use();
        test_branch();
        test_backpressure();
        test_flush();
        test_saturate();
        test_mid_reset();
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_leftover got %0d pending expected 0", exp_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
